// File: rtl/truth_table_sequencer.sv
// Sweeps {A,B,C} through 000..111, holds each vector for SETTLE_CYCLES, then
// compares the NAND and NOR implementations against the golden truth table.
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y_nand,
  input  logic       y_nor,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] vec_q;
  logic [3:0] settle_cnt_q;
  logic [2:0] abc_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] mismatch_q;
  logic [2:0] ffv_q;
  logic       ffvalid_q;
  logic       vec_fail;

  assign vec_fail = (y_nand != EXPECTED[vec_q]) || (y_nor != EXPECTED[vec_q]);

  // Outputs are loaded together with the state transition, so A/B/C always
  // track vec while busy and read 000 in IDLE and DONE.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q      <= IDLE;
      vec_q        <= 3'd0;
      settle_cnt_q <= 4'd0;
      abc_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= 4'd0;
      ffv_q        <= 3'd0;
      ffvalid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= SETTLE;
            vec_q        <= 3'd0;
            settle_cnt_q <= 4'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            mismatch_q   <= 4'd0;
            ffv_q        <= 3'd0;
            ffvalid_q    <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt_q <= settle_cnt_q + 4'd1;
          if (settle_cnt_q == 4'(SETTLE_CYCLES - 1)) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (vec_fail) begin
            if (mismatch_q < 4'd8) begin
              mismatch_q <= mismatch_q + 4'd1;
            end
            if (!ffvalid_q) begin
              ffv_q     <= vec_q;
              ffvalid_q <= 1'b1;
            end
          end
          if (vec_q != 3'd7) begin
            state_q      <= SETTLE;
            vec_q        <= vec_q + 3'd1;
            abc_q        <= vec_q + 3'd1;
            settle_cnt_q <= 4'd0;
          end else begin
            // Last vector's verdict is folded in here since mismatch_q updates this same edge.
            state_q <= DONE;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mismatch_q == 4'd0) && !vec_fail;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {A, B, C}        = abc_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mismatch_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: models the two implementations under test
// with selectable faults, runs a vector table of sweeps plus corner sequences.
module tb_truth_table_sequencer;

  localparam int S       = 2;
  localparam int SWEEP   = 1 + 8 * (S + 1);
  localparam int LIMIT   = 200;

  logic       clk = 1'b0;
  logic       rst, start, abort, y_nand, y_nor;
  logic       A, B, C, busy, done, pass, first_fail_valid;
  logic [3:0] mismatch_count;
  logic [2:0] first_fail_vec;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    int         mode;
    logic [3:0] mism;
    logic [2:0] ffv;
    logic       ffvalid;
    logic       pass;
  } vec_t;

  vec_t tbl[6];

  truth_table_sequencer #(.SETTLE_CYCLES(S), .EXPECTED(8'hE8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .y_nand(y_nand), .y_nor(y_nor),
    .A(A), .B(B), .C(C), .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mismatch_count), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid), .dbg_state_o(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Implementations under test: golden majority function with injectable faults.
  always_comb begin
    logic g;
    g      = (A & B) | (A & C) | (B & C);
    y_nand = g;
    y_nor  = g;
    case (mode)
      1: y_nor  = 1'b0;
      2: y_nand = ~g;
      3: y_nand = 1'b1;
      4: y_nor  = g ^ ({A, B, C} == 3'd6);
      5: begin
        y_nand = g ^ ({A, B, C} == 3'd7);
        y_nor  = g ^ ({A, B, C} == 3'd7);
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_abc"}, {A, B, C}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_mism"}, mismatch_count, 0);
    check({tag, "_ffv"}, first_fail_vec, 0);
    check({tag, "_ffvalid"}, first_fail_valid, 0);
  endtask

  // Pulses start, then counts edges until done; optionally scoreboards ABC
  // per cycle and re-pulses start while busy.
  task automatic run_sweep(input bit chk_abc, input bit extra_starts, output int cycles);
    logic [2:0] exp_v;
    exp_q.delete();
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < S + 1; k++) exp_q.push_back(3'(v));
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < LIMIT) begin
      if (chk_abc) begin
        if (exp_q.size() == 0) begin
          check("abc_overrun", {A, B, C}, 8);
        end else begin
          exp_v = exp_q.pop_front();
          check("sweep_abc", {A, B, C}, exp_v);
        end
        check("sweep_busy", busy, 1);
        check("sweep_pass_low", pass, 0);
      end
      start = extra_starts && (cycles == 5 || cycles == 10);
      tick();
      start = 1'b0;
      cycles++;
    end
    if (!done) check("done_timeout", done, 1);
    if (chk_abc) check("abc_left", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int guard;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tbl[0] = '{mode: 0, mism: 4'd0, ffv: 3'd0, ffvalid: 1'b0, pass: 1'b1};
    tbl[1] = '{mode: 1, mism: 4'd4, ffv: 3'd3, ffvalid: 1'b1, pass: 1'b0};
    tbl[2] = '{mode: 2, mism: 4'd8, ffv: 3'd0, ffvalid: 1'b1, pass: 1'b0};
    tbl[3] = '{mode: 3, mism: 4'd4, ffv: 3'd0, ffvalid: 1'b1, pass: 1'b0};
    tbl[4] = '{mode: 4, mism: 4'd1, ffv: 3'd6, ffvalid: 1'b1, pass: 1'b0};
    tbl[5] = '{mode: 5, mism: 4'd1, ffv: 3'd7, ffvalid: 1'b1, pass: 1'b0};

    tick(); tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_state", dbg_state, 0);

    // Table-driven sweeps
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      run_sweep(i == 0, 1'b0, cyc);
      check("sweep_cycles", cyc, SWEEP);
      check("done", done, 1);
      check("busy_in_done", busy, 0);
      check("abc_in_done", {A, B, C}, 0);
      check("mismatch_count", mismatch_count, tbl[i].mism);
      check("first_fail_vec", first_fail_vec, tbl[i].ffv);
      check("first_fail_valid", first_fail_valid, tbl[i].ffvalid);
      check("pass", pass, tbl[i].pass);
      tick();
      check("hold_mism", mismatch_count, tbl[i].mism);
      check("hold_done", done, 1);
    end

    // Start in DONE begins a fresh sweep with cleared results
    start = 1'b1; tick(); start = 1'b0;
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_mism", mismatch_count, 0);
    check("restart_ffvalid", first_fail_valid, 0);
    check("restart_pass", pass, 0);

    // Abort at vec 4 after four failures, with mode 2 still active
    mode = 2;
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while ({A, B, C} != 3'd4 && guard < LIMIT) begin tick(); guard++; end
    check("reach_vec4", {A, B, C}, 4);
    check("pre_abort_mism", mismatch_count, 4);
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort");
    check("abort_state", dbg_state, 0);
    run_sweep(1'b0, 1'b0, cyc);
    check("post_abort_cycles", cyc, SWEEP);
    check("post_abort_mism", mismatch_count, 8);

    // Reset mid-SETTLE
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_ffvalid", first_fail_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle("rst_mid");

    // Start pulses while busy leave timing unchanged
    mode = 0;
    run_sweep(1'b0, 1'b1, cyc);
    check("busy_start_cycles", cyc, SWEEP);
    check("busy_start_pass", pass, 1);

    // Abort beats start in DONE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("abort_prio_busy", busy, 0);
    check("abort_prio_done", done, 0);
    check("abort_prio_pass", pass, 0);

    // Reset beats start in IDLE
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", busy, 0);
    tick();
    check("rst_prio_stay", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst as across the codebase.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range 1..15.
REQ-003 Parameter EXPECTED, default 8'hE8: golden truth table; bit index = {A,B,C}.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a sweep; sampled only in IDLE and DONE.
REQ-007 abort  input  1  terminates a sweep; returns to IDLE.
REQ-008 y_nand  input  1  output of the NAND implementation under test.
REQ-009 y_nor  input  1  output of the NOR implementation under test.
REQ-010 A, B, C  output  1 each  stimulus driven to both implementations.
REQ-011 busy  output  1  high in SETTLE and CHECK.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  valid when done; 1 if mismatch_count == 0.
REQ-014 mismatch_count  output  4  number of failing vectors in the last sweep, 0..8.
REQ-015 first_fail_vec  output  3  {A,B,C} of the lowest-index failing vector.
REQ-016 first_fail_valid  output  1  high once any vector has failed in the current sweep.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE, with registered outputs only.
REQ-018 IDLE, on start=1: vec<=0, settle_cnt<=0, mismatch_count<=0, first_fail_valid<=0, first_fail_vec<=0; next state SETTLE.
REQ-019 {A,B,C} SHALL equal vec in SETTLE and CHECK, and 3'b000 in IDLE and DONE.
REQ-020 SETTLE: settle_cnt increments each cycle; the FSM enters CHECK when settle_cnt == SETTLE_CYCLES-1.
REQ-021 CHECK (one cycle): a vector fails if y_nand != EXPECTED[vec] or y_nor != EXPECTED[vec].
REQ-022 On a failing vector, mismatch_count increments by 1; if first_fail_valid is 0, first_fail_vec<=vec and first_fail_valid<=1.
REQ-023 CHECK with vec != 7: vec<=vec+1, settle_cnt<=0, next state SETTLE.
REQ-024 CHECK with vec == 7: next state DONE; vec SHALL NOT wrap.
REQ-025 Each vector SHALL occupy SETTLE_CYCLES+1 cycles; done SHALL rise exactly 1+8*(SETTLE_CYCLES+1) cycles after the start edge (25 cycles at default).
REQ-026 DONE: done=1 and pass=(mismatch_count==0); results hold until start, abort or rst.
REQ-027 start=1 in DONE SHALL begin a new sweep exactly as from IDLE (REQ-018).
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in any state SHALL go to IDLE, clearing vec, settle_cnt, mismatch_count, first_fail_vec and first_fail_valid.
REQ-030 abort has priority over start; if both are high in the same cycle, the FSM SHALL go to IDLE.
REQ-031 mismatch_count SHALL saturate at 8; it cannot exceed 8 by construction.
REQ-032 pass SHALL be 0 whenever done is 0.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, including mid-sweep.
REQ-034 Reset values: A=B=C=0, busy=0, done=0, pass=0, mismatch_count=0, first_fail_vec=0, first_fail_valid=0; internal vec and settle_cnt are 0.
REQ-035 rst SHALL have priority over abort and start.

Verification
REQ-036 Correct DUTs (both outputs = EXPECTED 8'hE8), SETTLE_CYCLES=2, start pulse -> ABC sweeps 000..111, 3 cycles per vector; done at +25 cycles; pass=1; mismatch_count=0.
REQ-037 y_nor stuck at 0 -> fails on vectors 3, 5, 6, 7; mismatch_count=4; first_fail_vec=3'b011; pass=0.
REQ-038 y_nand inverted for all vectors -> mismatch_count=8; first_fail_vec=0; first_fail_valid=1; pass=0.
REQ-039 abort asserted at vec=4 -> next cycle IDLE; ABC=000; busy=0; mismatch_count=0; a later start produces a full 25-cycle sweep.
REQ-040 rst asserted mid-SETTLE -> all outputs at reset values the next cycle; start pulses during busy leave timing unchanged.
REQ-041 start in DONE -> new sweep; counters cleared; done=0 the next cycle.
